alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
// Issue/retire stage wrapped around the ALU. Buffers decoded ALU requests in a small FIFO and drives the
// ALU operand/operation/execute inputs, one operation in flight. Waits on ALU busy, captures result+flags
// into a response register with valid/ready handshake toward writeback. Supports flag chaining (ADC/SBC)
// by feeding the last retired flags back as flags_in.
// PARAMETERS
// DEPTH     2   request FIFO entries (power of 2, >=2)
// MAX_WAIT  15  ce-cycles ALU busy may stay high after execute before err_timeout sets
// PORTS
// clk            in   1     clock
// reset_n        in   1     asynchronous, active-low reset
// ce             in   1     clock enable; all state and handshakes advance only when ce=1
// flush          in   1     sync: drop queued requests, pending response, in-flight result
// req_valid      in   1     request present
// req_ready      out  1     FIFO not full
// req_op         in   alu_operation_e  operation
// req_ta/req_tb  in   16    operands
// req_wide       in   1     1=16-bit, 0=8-bit
// req_flags      in   flags_t  flags_in when req_chain=0
// req_chain      in   1     1=use last retired flags as flags_in
// alu_operation  out  alu_operation_e  to ALU (registered)
// alu_ta/alu_tb  out  16    to ALU (registered)
// alu_wide       out  1     to ALU (registered)
// alu_flags_in   out  flags_t  to ALU (registered)
// alu_execute    out  1     one-ce-cycle execute pulse (registered)
// alu_busy       in   1     ALU busy
// alu_result     in   16    ALU result
// alu_flags      in   flags_t  ALU flags out
// rsp_valid      out  1     response held
// rsp_ready      in   1     consumer accepts
// rsp_result     out  16    captured result; upper byte zero when rsp_wide=0
// rsp_flags      out  flags_t  captured flags
// rsp_wide       out  1     width of captured op
// idle           out  1     FIFO empty, state IDLE, rsp_valid=0
// err_timeout    out  1     sticky; cleared only by reset
// BEHAVIOUR
// - Reset (async, reset_n=0): all outputs/regs 0 (alu_operation=ALU_OP_NONE, flags 0); FIFO empty;
//   last_flags=0; state IDLE; req_ready=1 after reset release. Mid-operation reset abandons the op.
// - FIFO: push on req_valid&req_ready&ce; req_ready=(count<DEPTH), no full-bypass; pointers wrap mod DEPTH.
// - FSM states IDLE, EXEC, WAIT, DRAIN:
//   IDLE: FIFO non-empty -> load alu_* from head, pop, alu_execute<=1, -> EXEC.
//         alu_flags_in = head.chain ? last_flags : head.flags.
//   EXEC: alu_execute<=0, wait_cnt<=0 -> WAIT.
//   WAIT: alu_busy=0 and (!rsp_valid | rsp_ready) -> rsp_*<=alu_*, rsp_valid<=1, last_flags<=alu_flags
//         -> IDLE. alu_busy=0 but slot full -> stay (ALU result holds, no new execute).
//         alu_busy=1 -> wait_cnt++ (saturating); wait_cnt==MAX_WAIT -> err_timeout<=1, stay.
//   DRAIN: wait alu_busy=0, discard, -> IDLE.
// - Latency: request accepted ce-cycle N -> alu_execute high N+2 -> rsp_valid high N+4 (1-cycle op).
//   Throughput one op per 3 ce-cycles.
// - rsp handshake: rsp_valid&rsp_ready&ce clears rsp_valid unless same-cycle capture reloads it.
//   rsp_* stable while rsp_valid=1 and rsp_ready=0.
// - rsp_result: captured value masked to 8 bits when alu_wide=0.
// - last_flags updates only on capture, never on flush-discarded ops.
// - flush (ce=1): FIFO emptied, rsp_valid<=0, alu_execute<=0; EXEC/WAIT -> DRAIN; flush beats push.
// - ALU_OP_NONE: issued normally; rsp_flags = flags_in passthrough; rsp_result = ALU's held value.
// - ce=0: no state change, alu_execute held (ALU also gated by ce).
// TESTING
// - reset_n low mid-WAIT -> next cycle all outputs 0, idle=1, req_ready=1.
// - ADD ta=0x00FF tb=0x0001 wide=1 accepted cycle N -> execute N+2; rsp_valid N+4, result 0x0100, CY=0 AC=1 Z=0.
// - ADD ta=0xFF tb=0x01 wide=0, then chained req -> first rsp 0x00, Z=1 CY=1; second alu_flags_in.CY=1.
// - 3 back-to-back pushes, DEPTH=2, rsp_ready=0 -> req_ready drops after 2 queued; FSM holds WAIT; release -> order preserved.
// - flush asserted in cycle N+2 of an op -> DRAIN, no rsp_valid, FIFO empty, last_flags unchanged.
// - alu_busy forced high 16 ce-cycles -> err_timeout=1 and stays set until reset.

Source files
------------

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue -- issue/retire stage wrapped around an external ALU.
//
// Decoded ALU requests are buffered in a small FIFO. One request at a time is
// loaded into registered ALU operand/operation inputs together with a single
// execute pulse; once the ALU drops busy, its result and flags are captured
// into a response register that is handed to writeback with valid/ready.
// The last captured flags are kept so that chained ops (ADC/SBC) can take
// their flags_in from the previous retired op.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   ce                  clock enable; nothing advances while ce=0
//   flush               drop queued requests, pending response, in-flight op
//   req_*               request stream (valid/ready), operands, width, flags
//   alu_*  (out)        registered operation/operands/flags_in/execute to ALU
//   alu_busy/result/flags (in)  ALU status and outputs
//   rsp_*               response register toward writeback (valid/ready)
//   idle                FIFO empty, FSM idle, no response held
//   err_timeout         sticky: ALU busy stayed high longer than MAX_WAIT
// ---------------------------------------------------------------------------
package alu_issue_pkg;

    typedef enum logic [2:0] {
        ALU_OP_NONE = 3'd0,
        ALU_OP_ADD  = 3'd1,
        ALU_OP_ADC  = 3'd2,
        ALU_OP_SUB  = 3'd3,
        ALU_OP_SBC  = 3'd4,
        ALU_OP_AND  = 3'd5,
        ALU_OP_OR   = 3'd6,
        ALU_OP_XOR  = 3'd7
    } alu_operation_e;

    typedef struct packed {
        logic cy;   // carry / borrow
        logic ac;   // auxiliary (nibble) carry
        logic ov;   // signed overflow
        logic s;    // sign
        logic z;    // zero
    } flags_t;

    typedef struct packed {
        alu_operation_e op;
        logic [15:0]    ta;
        logic [15:0]    tb;
        logic           wide;
        flags_t         flags;
        logic           chain;
    } req_t;

endpackage

module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce,
    input  logic           flush,

    input  logic           req_valid,
    output logic           req_ready,
    input  alu_operation_e req_op,
    input  logic [15:0]    req_ta,
    input  logic [15:0]    req_tb,
    input  logic           req_wide,
    input  flags_t         req_flags,
    input  logic           req_chain,

    output alu_operation_e alu_operation,
    output logic [15:0]    alu_ta,
    output logic [15:0]    alu_tb,
    output logic           alu_wide,
    output flags_t         alu_flags_in,
    output logic           alu_execute,
    input  logic           alu_busy,
    input  logic [15:0]    alu_result,
    input  flags_t         alu_flags,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [15:0]    rsp_result,
    output flags_t         rsp_flags,
    output logic           rsp_wide,

    output logic           idle,
    output logic           err_timeout
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT,
        ST_DRAIN
    } state_e;

    // -----------------------------------------------------------------------
    // Request FIFO
    // -----------------------------------------------------------------------
    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    req_t             head;
    req_t             push_entry;

    state_e           state_q;

    assign fifo_empty = (count_q == '0);
    assign req_ready  = (count_q < CNT_W'(DEPTH));
    // flush has priority over both ends of the FIFO.
    assign push       = ce && !flush && req_valid && req_ready;
    assign pop        = ce && !flush && (state_q == ST_IDLE) && !fifo_empty;
    assign head       = mem[rd_ptr_q];

    assign push_entry = '{op: req_op, ta: req_ta, tb: req_tb, wide: req_wide,
                          flags: req_flags, chain: req_chain};

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first, so no path leaves a value unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (ce && flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only read when
    // count_q says they were written, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_entry;
    end

    // -----------------------------------------------------------------------
    // Issue / retire FSM with registered ALU and response outputs
    // -----------------------------------------------------------------------
    alu_operation_e    alu_operation_q;
    logic [15:0]       alu_ta_q, alu_tb_q;
    logic              alu_wide_q;
    flags_t            alu_flags_in_q;
    logic              alu_execute_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_result_q;
    flags_t            rsp_flags_q;
    logic              rsp_wide_q;
    flags_t            last_flags_q;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic              err_timeout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            alu_operation_q <= ALU_OP_NONE;
            alu_ta_q        <= '0;
            alu_tb_q        <= '0;
            alu_wide_q      <= 1'b0;
            alu_flags_in_q  <= '0;
            alu_execute_q   <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_result_q    <= '0;
            rsp_flags_q     <= '0;
            rsp_wide_q      <= 1'b0;
            last_flags_q    <= '0;
            wait_cnt_q      <= '0;
            err_timeout_q   <= 1'b0;
        end else if (ce) begin
            // Consumer handshake; a capture below in the same cycle reloads it.
            if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;

            if (flush) begin
                alu_execute_q <= 1'b0;
                rsp_valid_q   <= 1'b0;
                // An op already handed to the ALU must finish before reuse.
                if (state_q == ST_EXEC || state_q == ST_WAIT) begin
                    state_q <= ST_DRAIN;
                end else if (state_q == ST_DRAIN && !alu_busy) begin
                    state_q <= ST_IDLE;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!fifo_empty) begin
                            alu_operation_q <= head.op;
                            alu_ta_q        <= head.ta;
                            alu_tb_q        <= head.tb;
                            alu_wide_q      <= head.wide;
                            alu_flags_in_q  <= head.chain ? last_flags_q : head.flags;
                            alu_execute_q   <= 1'b1;
                            state_q         <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        alu_execute_q <= 1'b0;
                        wait_cnt_q    <= '0;
                        state_q       <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (alu_busy) begin
                            // Counter saturates at MAX_WAIT; the error is sticky.
                            if (wait_cnt_q == WCNT_W'(MAX_WAIT)) err_timeout_q <= 1'b1;
                            else                                  wait_cnt_q    <= wait_cnt_q + WCNT_W'(1);
                        end else if (!rsp_valid_q || rsp_ready) begin
                            rsp_result_q <= alu_wide_q ? alu_result : {8'h00, alu_result[7:0]};
                            rsp_flags_q  <= alu_flags;
                            rsp_wide_q   <= alu_wide_q;
                            rsp_valid_q  <= 1'b1;
                            last_flags_q <= alu_flags;
                            state_q      <= ST_IDLE;
                        end
                        // Result ready but slot occupied: hold, the ALU keeps its output.
                    end
                    ST_DRAIN: begin
                        if (!alu_busy) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign alu_operation = alu_operation_q;
    assign alu_ta        = alu_ta_q;
    assign alu_tb        = alu_tb_q;
    assign alu_wide      = alu_wide_q;
    assign alu_flags_in  = alu_flags_in_q;
    assign alu_execute   = alu_execute_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_flags     = rsp_flags_q;
    assign rsp_wide      = rsp_wide_q;
    assign err_timeout   = err_timeout_q;
    assign idle          = fifo_empty && (state_q == ST_IDLE) && !rsp_valid_q;

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue -- self-checking bench for alu_issue.
// A small behavioural ALU (one-cycle ops, busy driven by the bench) answers
// the DUT; expected responses are hand-computed constants in a vector table,
// followed by directed sequences for latency, backpressure, flush, clock
// enable, timeout and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           ce = 1'b1;
    logic           flush = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    alu_operation_e req_op = ALU_OP_NONE;
    logic [15:0]    req_ta = '0, req_tb = '0;
    logic           req_wide = 1'b0;
    flags_t         req_flags = '0;
    logic           req_chain = 1'b0;
    alu_operation_e alu_operation;
    logic [15:0]    alu_ta, alu_tb;
    logic           alu_wide;
    flags_t         alu_flags_in;
    logic           alu_execute;
    logic           alu_busy = 1'b0;
    logic [15:0]    alu_result;
    flags_t         alu_flags;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [15:0]    rsp_result;
    flags_t         rsp_flags;
    logic           rsp_wide;
    logic           idle;
    logic           err_timeout;

    int total = 0;
    int bad   = 0;

    alu_issue #(.DEPTH(2), .MAX_WAIT(15)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_ta(req_ta), .req_tb(req_tb), .req_wide(req_wide),
        .req_flags(req_flags), .req_chain(req_chain),
        .alu_operation(alu_operation), .alu_ta(alu_ta), .alu_tb(alu_tb),
        .alu_wide(alu_wide), .alu_flags_in(alu_flags_in), .alu_execute(alu_execute),
        .alu_busy(alu_busy), .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_wide(rsp_wide),
        .idle(idle), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    typedef struct packed {
        logic [15:0] r;
        flags_t      f;
    } alu_out_t;

    function automatic alu_out_t alu_model(alu_operation_e op, logic [15:0] ta, logic [15:0] tb,
                                           logic wide, flags_t fin, logic [15:0] held);
        alu_out_t    o;
        logic [16:0] s17;
        logic [8:0]  s9;
        logic [4:0]  nib;
        logic        c, am, bm, rm;
        o.r = held;
        o.f = fin;
        c   = ((op == ALU_OP_ADC) || (op == ALU_OP_SBC)) ? fin.cy : 1'b0;
        am  = wide ? ta[15] : ta[7];
        bm  = wide ? tb[15] : tb[7];
        if (op != ALU_OP_NONE) begin
            s17 = '0; s9 = '0; nib = '0;
            case (op)
                ALU_OP_ADD, ALU_OP_ADC: begin
                    s17 = {1'b0, ta} + {1'b0, tb} + 17'(c);
                    s9  = {1'b0, ta[7:0]} + {1'b0, tb[7:0]} + 9'(c);
                    nib = {1'b0, ta[3:0]} + {1'b0, tb[3:0]} + 5'(c);
                    o.r = s17[15:0];
                end
                ALU_OP_SUB, ALU_OP_SBC: begin
                    s17 = {1'b0, ta} - {1'b0, tb} - 17'(c);
                    s9  = {1'b0, ta[7:0]} - {1'b0, tb[7:0]} - 9'(c);
                    nib = {1'b0, ta[3:0]} - {1'b0, tb[3:0]} - 5'(c);
                    o.r = s17[15:0];
                end
                ALU_OP_AND: o.r = ta & tb;
                ALU_OP_OR:  o.r = ta | tb;
                default:    o.r = ta ^ tb;
            endcase
            rm     = wide ? o.r[15] : o.r[7];
            o.f.cy = wide ? s17[16] : s9[8];
            o.f.ac = nib[4];
            if (op == ALU_OP_ADD || op == ALU_OP_ADC)      o.f.ov = (am == bm) && (rm != am);
            else if (op == ALU_OP_SUB || op == ALU_OP_SBC) o.f.ov = (am != bm) && (rm != am);
            else                                           o.f.ov = 1'b0;
            o.f.s  = rm;
            o.f.z  = wide ? (o.r == 16'h0) : (o.r[7:0] == 8'h0);
        end
        return o;
    endfunction

    alu_out_t m_out;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_out <= '0;
        else if (ce && alu_execute)
            m_out <= alu_model(alu_operation, alu_ta, alu_tb, alu_wide, alu_flags_in, m_out.r);
    end
    assign alu_result = m_out.r;
    assign alu_flags  = m_out.f;

    // Execute monitor: counts pulses and remembers the flags_in presented.
    int     exec_cnt = 0;
    flags_t last_fin = '0;
    always @(posedge clk) begin
        if (reset_n && ce && alu_execute) begin
            exec_cnt <= exec_cnt + 1;
            last_fin <= alu_flags_in;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns just after the edge that accepted it.
    task automatic push_req(input alu_operation_e op, input logic [15:0] ta, input logic [15:0] tb,
                            input logic wide, input flags_t fl, input logic chain);
        int n;
        req_op = op; req_ta = ta; req_tb = tb; req_wide = wide; req_flags = fl; req_chain = chain;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            step();
            n++;
        end
        if (!req_ready) check("push_ready_timeout", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        for (int i = 0; i < 40 && !rsp_valid; i++) step();
        check({name, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    endtask

    typedef struct packed {
        alu_operation_e op;
        logic [15:0]    ta;
        logic [15:0]    tb;
        logic           wide;
        flags_t         fl;
        logic           chain;
        logic [15:0]    exp_res;
        flags_t         exp_fl;
        flags_t         exp_fin;
    } vec_t;

    task automatic run_vec(input vec_t v, input string name);
        push_req(v.op, v.ta, v.tb, v.wide, v.fl, v.chain);
        wait_rsp(name);
        check({name, "_result"}, 32'(rsp_result), 32'(v.exp_res));
        check({name, "_flags"},  32'(rsp_flags),  32'(v.exp_fl));
        check({name, "_wide"},   32'(rsp_wide),   32'(v.wide));
        check({name, "_fin"},    32'(last_fin),   32'(v.exp_fin));
    endtask

    vec_t         vecs [12];
    logic [15:0]  got_q[$];
    int           ec;

    initial begin
        // flags literals are {cy, ac, ov, s, z}
        vecs[0]  = '{ALU_OP_ADD, 16'h00FF, 16'h0001, 1'b1, flags_t'(5'b00100), 1'b0, 16'h0100, flags_t'(5'b01000), flags_t'(5'b00100)};
        vecs[1]  = '{ALU_OP_ADD, 16'h00FF, 16'h0001, 1'b0, flags_t'(5'b00000), 1'b0, 16'h0000, flags_t'(5'b11001), flags_t'(5'b00000)};
        vecs[2]  = '{ALU_OP_ADC, 16'h0010, 16'h0020, 1'b0, flags_t'(5'b00000), 1'b1, 16'h0031, flags_t'(5'b00000), flags_t'(5'b11001)};
        vecs[3]  = '{ALU_OP_SUB, 16'h1000, 16'h0001, 1'b1, flags_t'(5'b00000), 1'b0, 16'h0FFF, flags_t'(5'b01000), flags_t'(5'b00000)};
        vecs[4]  = '{ALU_OP_SUB, 16'h0005, 16'h0007, 1'b0, flags_t'(5'b00000), 1'b0, 16'h00FE, flags_t'(5'b11010), flags_t'(5'b00000)};
        vecs[5]  = '{ALU_OP_SBC, 16'h8000, 16'h0000, 1'b1, flags_t'(5'b00000), 1'b1, 16'h7FFF, flags_t'(5'b01100), flags_t'(5'b11010)};
        vecs[6]  = '{ALU_OP_XOR, 16'hA5A5, 16'hA5A5, 1'b1, flags_t'(5'b10101), 1'b0, 16'h0000, flags_t'(5'b00001), flags_t'(5'b10101)};
        vecs[7]  = '{ALU_OP_AND, 16'hF0F0, 16'hFF00, 1'b1, flags_t'(5'b00000), 1'b0, 16'hF000, flags_t'(5'b00010), flags_t'(5'b00000)};
        vecs[8]  = '{ALU_OP_OR,  16'h1230, 16'h0045, 1'b0, flags_t'(5'b00000), 1'b0, 16'h0075, flags_t'(5'b00000), flags_t'(5'b00000)};
        vecs[9]  = '{ALU_OP_NONE, 16'h0000, 16'h0000, 1'b1, flags_t'(5'b10110), 1'b0, 16'h1275, flags_t'(5'b10110), flags_t'(5'b10110)};
        vecs[10] = '{ALU_OP_NONE, 16'h0000, 16'h0000, 1'b0, flags_t'(5'b00011), 1'b0, 16'h0075, flags_t'(5'b00011), flags_t'(5'b00011)};
        vecs[11] = '{ALU_OP_ADC, 16'h7FFF, 16'h0001, 1'b1, flags_t'(5'b11111), 1'b1, 16'h8000, flags_t'(5'b01110), flags_t'(5'b00011)};

        // ---- reset state ----
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("rst_alu_ops", {alu_ta, alu_tb}, 32'h0);
        check("rst_alu_ctl", 32'({alu_operation, alu_wide, alu_flags_in, alu_execute}), 32'h0);
        check("rst_rsp", 32'({rsp_valid, rsp_result, rsp_flags, rsp_wide}), 32'h0);
        check("rst_status", 32'({idle, req_ready, err_timeout}), 32'b110);

        // ---- latency: accept at N, execute at N+2, rsp_valid at N+4 ----
        push_req(ALU_OP_ADD, 16'h00FF, 16'h0001, 1'b1, flags_t'(5'b0), 1'b0);
        check("lat_n1_exec", 32'(alu_execute), 32'd0);
        step();
        check("lat_n2_exec", 32'(alu_execute), 32'd1);
        check("lat_n2_ops", {alu_ta, alu_tb}, 32'h00FF_0001);
        step();
        check("lat_n3_exec", 32'(alu_execute), 32'd0);
        check("lat_n3_rsp", 32'(rsp_valid), 32'd0);
        step();
        check("lat_n4_rsp", 32'(rsp_valid), 32'd1);
        check("lat_n4_result", 32'(rsp_result), 32'h0100);
        check("lat_n4_flags", 32'(rsp_flags), 32'(5'b01000));

        // ---- vector table ----
        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // ---- backpressure: DEPTH=2, three back-to-back pushes ----
        step();
        rsp_ready = 1'b0;
        push_req(ALU_OP_ADD, 16'h0001, 16'h0001, 1'b1, flags_t'(5'b0), 1'b0);
        push_req(ALU_OP_ADD, 16'h0003, 16'h0003, 1'b1, flags_t'(5'b0), 1'b0);
        push_req(ALU_OP_ADD, 16'h0005, 16'h0005, 1'b1, flags_t'(5'b0), 1'b0);
        check("bp_full_ready", 32'(req_ready), 32'd0);
        repeat (10) step();
        check("bp_hold_valid", 32'(rsp_valid), 32'd1);
        check("bp_hold_result", 32'(rsp_result), 32'h0002);
        check("bp_hold_status", 32'({idle, alu_execute, req_ready}), 32'b001);
        repeat (3) step();
        check("bp_stable_result", 32'(rsp_result), 32'h0002);
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) got_q.push_back(rsp_result);
            step();
        end
        check("bp_count", 32'(got_q.size()), 32'd3);
        while (got_q.size() < 3) got_q.push_back(16'hDEAD);
        check("bp_order0", 32'(got_q[0]), 32'h0002);
        check("bp_order1", 32'(got_q[1]), 32'h0006);
        check("bp_order2", 32'(got_q[2]), 32'h000A);

        // ---- flush during EXEC; last_flags must survive ----
        run_vec('{ALU_OP_ADD, 16'h00FF, 16'h0001, 1'b0, flags_t'(5'b0), 1'b0, 16'h0000, flags_t'(5'b11001), flags_t'(5'b0)}, "fl_prep");
        push_req(ALU_OP_AND, 16'h0000, 16'h0000, 1'b1, flags_t'(5'b0), 1'b0);
        step();
        check("fl_exec_before", 32'(alu_execute), 32'd1);
        flush = 1'b1;
        req_op = ALU_OP_ADD; req_ta = 16'h0001; req_tb = 16'h0001; req_valid = 1'b1;
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        ec = exec_cnt;
        check("fl_drain_status", 32'({alu_execute, rsp_valid, idle}), 32'b000);
        repeat (6) step();
        check("fl_no_rsp", 32'(rsp_valid), 32'd0);
        check("fl_idle", 32'(idle), 32'd1);
        check("fl_no_exec", 32'(exec_cnt - ec), 32'd0);
        run_vec('{ALU_OP_ADC, 16'h0000, 16'h0000, 1'b0, flags_t'(5'b0), 1'b1, 16'h0001, flags_t'(5'b0), flags_t'(5'b11001)}, "fl_chain");

        // ---- ce=0 freezes the pipeline ----
        push_req(ALU_OP_ADD, 16'h0002, 16'h0003, 1'b1, flags_t'(5'b0), 1'b0);
        step();
        ce = 1'b0;
        repeat (3) step();
        check("ce_exec_held", 32'(alu_execute), 32'd1);
        check("ce_no_rsp", 32'(rsp_valid), 32'd0);
        ce = 1'b1;
        wait_rsp("ce");
        check("ce_result", 32'(rsp_result), 32'h0005);

        // ---- timeout ----
        alu_busy = 1'b1;
        push_req(ALU_OP_ADD, 16'h0001, 16'h0002, 1'b1, flags_t'(5'b0), 1'b0);
        repeat (10) step();
        check("to_early", 32'(err_timeout), 32'd0);
        repeat (10) step();
        check("to_set", 32'(err_timeout), 32'd1);
        check("to_no_rsp", 32'(rsp_valid), 32'd0);
        alu_busy = 1'b0;
        wait_rsp("to");
        check("to_result", 32'(rsp_result), 32'h0003);
        repeat (5) step();
        check("to_sticky", 32'(err_timeout), 32'd1);

        // ---- asynchronous reset while in WAIT ----
        alu_busy = 1'b1;
        push_req(ALU_OP_SUB, 16'h0009, 16'h0001, 1'b1, flags_t'(5'b0), 1'b0);
        repeat (4) step();
        reset_n = 1'b0;
        #2;
        check("ar_alu_ctl", 32'({alu_operation, alu_wide, alu_flags_in, alu_execute}), 32'h0);
        check("ar_rsp", 32'({rsp_valid, rsp_result, rsp_flags, rsp_wide}), 32'h0);
        check("ar_status", 32'({idle, req_ready, err_timeout}), 32'b110);
        alu_busy = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
        check("ar_after", 32'({idle, req_ready, err_timeout, rsp_valid, alu_execute}), 32'b11000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
